dir_hist_peak: RTL and testbench
================================

DIR_HIST_PEAK -- requirements
Module: dir_hist_peak

Interface
REQ-001 Parameter: MAG_W, 8, gradient magnitude width in bits.
REQ-002 Parameter: ACC_W, 16, width of each histogram bin accumulator in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port: start  input  1  single-cycle request to open a new keypoint window.
REQ-006 Port: in_valid  input  1  sample valid.
REQ-007 Port: in_dir  input  5  direction bin code, 0..31, as produced by the direction ROMs.
REQ-008 Port: in_mag  input  MAG_W  gradient magnitude (weight) of the sample.
REQ-009 Port: in_last  input  1  marks the final sample of the window; qualified by in_valid.
REQ-010 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-011 Port: out_valid  output  1  result valid; held until accepted.
REQ-012 Port: out_ready  input  1  downstream accepts the result.
REQ-013 Port: out_dir  output  5  dominant direction bin.
REQ-014 Port: out_peak  output  ACC_W  accumulated weight of the dominant bin.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ACCUM, SCAN and DONE.
REQ-017 IDLE: start SHALL clear all 32 bins in the same edge and move the FSM to ACCUM; other inputs are ignored in IDLE.
REQ-018 start SHALL be ignored in ACCUM, SCAN and DONE.
REQ-019 ACCUM: in_ready SHALL be 1, and it SHALL be 0 in every other state.
REQ-020 A sample is accepted on an edge where in_valid and in_ready are both 1; bin[in_dir] SHALL add the zero-extended in_mag on that edge.
REQ-021 Accumulation SHALL saturate at 2^ACC_W-1 and never wrap.
REQ-022 Back-to-back samples to the same bin SHALL each be counted; throughput SHALL be one sample per cycle with no bubbles.
REQ-023 An accepted sample with in_last=1 SHALL be accumulated and SHALL move the FSM to SCAN on the same edge.
REQ-024 SCAN: one bin per cycle, ascending index 0..31, against a running max (starting value 0, index 0).
REQ-025 A bin SHALL replace the running max only if it is strictly greater, so on a tie the lowest index wins.
REQ-026 After bin 31 the FSM SHALL enter DONE, with out_valid rising 33 cycles after the in_last acceptance edge.
REQ-027 DONE: out_valid=1, with out_dir and out_peak stable.
REQ-028 Result handshake (out_valid and out_ready both 1): the FSM SHALL return to IDLE on that edge and out_valid SHALL fall.
REQ-029 All-zero histogram: out_dir=0 and out_peak=0.
REQ-030 Bin contents SHALL persist after DONE until the next start.

Reset
REQ-031 While rst_n=0, regardless of clk:
- FSM=IDLE
- all bins=0
- in_ready=0, out_valid=0, busy=0
- out_dir=0, out_peak=0
REQ-032 Reset asserted mid-ACCUM or mid-SCAN SHALL abandon the window with no result emitted.
REQ-033 After rst_n deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-034 Stream: start, then samples (dir 3, mag 10), (dir 7, mag 25), (dir 3, mag 20, last) -> out_dir=3, out_peak=30, out_valid 33 cycles after last.
REQ-035 Tie: 5 samples (dir 9, mag 40) and 5 samples (dir 2, mag 40), last on the 10th -> out_dir=2, out_peak=200.
REQ-036 Saturation (ACC_W=16): 300 samples (dir 31, mag 255) -> out_peak=65535, out_dir=31.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, busy=1; out_ready=1 -> IDLE on the next edge, in_ready stays 0.
REQ-038 Drive rst_n=0 mid-ACCUM after 4 samples, release it, then start and one sample (dir 0, mag 1, last) -> out_dir=0, out_peak=1; no stale bins.
REQ-039 Ignored inputs: start during SCAN and in_valid during IDLE or SCAN -> no effect on the bins or the result.

Source files
------------

// File: rtl/dir_hist_peak.sv
// Orientation histogram peak finder: accumulates weighted samples into 32 direction bins,
// then scans them one per cycle to report the dominant direction and its weight.
module dir_hist_peak #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [4:0]       in_dir,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_dir,
  output logic [ACC_W-1:0] out_peak,
  output logic             busy
);

  localparam int NBINS = 32;

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] bin_q [NBINS];
  logic [5:0]       scan_idx_q, scan_idx_d;
  logic [4:0]       max_dir_q, max_dir_d;
  logic [ACC_W-1:0] max_val_q, max_val_d;

  logic             accept;
  logic             clear_bins;
  logic [ACC_W:0]   mag_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sat_sum;
  logic [ACC_W-1:0] scan_bin;

  // One spare bit catches the carry so the bin clamps at all-ones instead of wrapping.
  assign mag_ext  = {{(ACC_W + 1 - MAG_W){1'b0}}, in_mag};
  assign sum      = {1'b0, bin_q[in_dir]} + mag_ext;
  assign sat_sum  = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign scan_bin = bin_q[scan_idx_q[4:0]];

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no latch is inferred.
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    max_dir_d  = max_dir_q;
    max_val_d  = max_val_q;
    in_ready   = 1'b0;
    accept     = 1'b0;
    clear_bins = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clear_bins = 1'b1;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (in_last) begin
            state_d    = SCAN;
            scan_idx_d = '0;
            max_dir_d  = '0;
            max_val_d  = '0;
          end
        end
      end
      SCAN: begin
        // Index 32 is a terminal cycle after bin 31, giving 33 cycles from last sample to result.
        if (scan_idx_q[5]) begin
          state_d = DONE;
        end else begin
          if (scan_bin > max_val_q) begin
            max_val_d = scan_bin;
            max_dir_d = scan_idx_q[4:0];
          end
          scan_idx_d = scan_idx_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_dir   = max_dir_q;
  assign out_peak  = max_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      max_dir_q  <= '0;
      max_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      max_dir_q  <= max_dir_d;
      max_val_q  <= max_val_d;
    end
  end

  // NOTE: the bins are flops, not RAM, because reset and start must clear all 32 at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
    end else if (clear_bins) begin
      for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
    end else if (accept) begin
      bin_q[in_dir] <= sat_sum;
    end
  end

endmodule

// File: tb/tb_dir_hist_peak.sv
// Directed self-checking bench for dir_hist_peak: accumulation, tie-break, saturation,
// backpressure, ignored inputs and mid-window reset.
module tb_dir_hist_peak;

  localparam int MAG_W = 8;
  localparam int ACC_W = 16;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [4:0]       in_dir    = '0;
  logic [MAG_W-1:0] in_mag    = '0;
  logic             in_last   = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [4:0]       out_dir;
  logic [ACC_W-1:0] out_peak;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  dir_hist_peak #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_dir    (in_dir),
    .in_mag    (in_mag),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dir   (out_dir),
    .out_peak  (out_peak),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic open_window();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] d, input logic [MAG_W-1:0] m, input logic l);
    in_valid = 1'b1;
    in_dir   = d;
    in_mag   = m;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts cycles from the last-sample edge until out_valid, bounded at 100.
  task automatic wait_result(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ovalid_fall"}, out_valid, 1'b0);
    check({tag, "_busy_idle"},   busy,      1'b0);
    check({tag, "_iready_idle"}, in_ready,  1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_out_dir",   out_dir,   5'd0);
    check("rst_out_peak",  out_peak,  16'd0);
    rst_n = 1'b1;

    // Samples while IDLE are ignored
    in_valid = 1'b1; in_dir = 5'd5; in_mag = 8'd99; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("idle_ignore_busy", busy, 1'b0);

    // Basic stream
    open_window();
    check("accum_busy",     busy,     1'b1);
    check("accum_in_ready", in_ready, 1'b1);
    send(5'd3, 8'd10, 1'b0);
    send(5'd7, 8'd25, 1'b0);
    send(5'd3, 8'd20, 1'b1);
    check("scan_in_ready", in_ready, 1'b0);
    check("scan_busy",     busy,     1'b1);
    start = 1'b1; in_valid = 1'b1; in_dir = 5'd3; in_mag = 8'd255; in_last = 1'b1;
    wait_result(lat);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("stream_latency", lat,      33);
    check("stream_dir",     out_dir,  5'd3);
    check("stream_peak",    out_peak, 16'd30);
    finish_result("stream");

    // Tie: lowest index wins; back-to-back same-bin samples all counted
    open_window();
    for (int i = 0; i < 5; i++) send(5'd9, 8'd40, 1'b0);
    for (int i = 0; i < 4; i++) send(5'd2, 8'd40, 1'b0);
    send(5'd2, 8'd40, 1'b1);
    wait_result(lat);
    check("tie_latency", lat,      33);
    check("tie_dir",     out_dir,  5'd2);
    check("tie_peak",    out_peak, 16'd200);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_dir",   out_dir,   5'd2);
      check("bp_out_peak",  out_peak,  16'd200);
      check("bp_busy",      busy,      1'b1);
      check("bp_in_ready",  in_ready,  1'b0);
    end
    finish_result("bp");

    // Saturation
    open_window();
    for (int i = 0; i < 299; i++) send(5'd31, 8'd255, 1'b0);
    send(5'd31, 8'd255, 1'b1);
    wait_result(lat);
    check("sat_latency", lat,      33);
    check("sat_dir",     out_dir,  5'd31);
    check("sat_peak",    out_peak, 16'd65535);
    finish_result("sat");

    // All-zero histogram; also shows the saturated bin was cleared by start
    open_window();
    send(5'd4, 8'd0, 1'b1);
    wait_result(lat);
    check("zero_latency", lat,      33);
    check("zero_dir",     out_dir,  5'd0);
    check("zero_peak",    out_peak, 16'd0);
    finish_result("zero");

    // Reset mid-ACCUM, then a fresh one-sample window
    open_window();
    send(5'd0, 8'd50, 1'b0);
    send(5'd5, 8'd60, 1'b0);
    send(5'd5, 8'd70, 1'b0);
    send(5'd9, 8'd80, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_accum_busy",      busy,      1'b0);
    check("rst_accum_in_ready",  in_ready,  1'b0);
    check("rst_accum_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    open_window();
    check("post_rst_start_busy", busy, 1'b1);
    send(5'd0, 8'd1, 1'b1);
    wait_result(lat);
    check("post_rst_latency", lat,      33);
    check("post_rst_dir",     out_dir,  5'd0);
    check("post_rst_peak",    out_peak, 16'd1);
    finish_result("post_rst");

    // Reset mid-SCAN after bin 6 has become the running max: no result emitted
    open_window();
    send(5'd6, 8'd7, 1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_scan_busy",     busy,     1'b0);
    check("rst_scan_out_dir",  out_dir,  5'd0);
    check("rst_scan_out_peak", out_peak, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    check("rst_scan_no_result", seen, 0);
    check("rst_scan_idle",      busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
